// File: rtl/cache_port_arbiter.sv
// ---------------------------------------------------------------------------
// cache_port_arbiter
//
// Purpose:
//   Arbitrates between two CPU-side requesters (port 0: load unit, port 1:
//   store unit) for the single request port of the L1_D cache. One request
//   is accepted, issued to the cache as a one-cycle strobe, and the cache's
//   completion (with 128-bit read data) is returned to the requester that
//   was served as a one-cycle response pulse.
//
//   Sequence: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   When both requesters ask at once, the one not served last wins; the
//   last-served pointer resets to port 1, so port 0 wins the first tie.
//
// Optional feature (compile-time macro CACHE_ARB_TIMEOUT_EN):
//   Defined   : WAIT is bounded by TIMEOUT cycles; on expiry the response
//               carries resp_err = 1 and resp_data = 0.
//   Undefined : WAIT lasts until cache_done; resp_err is tied to 0.
//
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   reqN/weN/addrN/wdataN/
//   sizeN/clfN  (N = 0,1)     requester N request and request fields
//   ackN                      one-cycle pulse, request N accepted
//   respN_valid               one-cycle pulse, request N complete
//   resp_err, resp_data       response status / read data
//   cache_req                 one-cycle issue strobe to L1_D
//   cache_we/addr/wdata/
//   size/clf                  latched request fields to L1_D
//   cache_done, cache_rdata   L1_D completion pulse and read data
//   busy                      high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module cache_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int WDATA_W = 64,
    parameter int RDATA_W = 128,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               req0,
    input  logic               we0,
    input  logic [ADDR_W-1:0]  addr0,
    input  logic [WDATA_W-1:0] wdata0,
    input  logic [2:0]         size0,
    input  logic               clf0,
    output logic               ack0,
    output logic               resp0_valid,

    input  logic               req1,
    input  logic               we1,
    input  logic [ADDR_W-1:0]  addr1,
    input  logic [WDATA_W-1:0] wdata1,
    input  logic [2:0]         size1,
    input  logic               clf1,
    output logic               ack1,
    output logic               resp1_valid,

    output logic               resp_err,
    output logic [RDATA_W-1:0] resp_data,

    output logic               cache_req,
    output logic               cache_we,
    output logic [ADDR_W-1:0]  cache_addr,
    output logic [WDATA_W-1:0] cache_wdata,
    output logic [2:0]         cache_size,
    output logic               cache_clf,
    input  logic               cache_done,
    input  logic [RDATA_W-1:0] cache_rdata,

    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic winner_q;     // port being served by the current transaction
    logic last_q;       // port served by the most recent completed issue
    logic sel;          // arbitration result for this cycle
    logic accept;
    logic timeout_hit;

    assign accept = (state_q == IDLE) && (req0 || req1);

    // A lone request wins outright; on a tie the port not served last wins.
    always_comb begin
        sel = req1;
        if (req0 && req1) begin
            sel = ~last_q;
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next state and decoded strobes ----------------
    always_comb begin
        state_d     = state_q;
        ack0        = 1'b0;
        ack1        = 1'b0;
        cache_req   = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        busy        = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (req0 || req1) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cache_req = 1'b1;
                ack0      = ~winner_q;
                ack1      = winner_q;
                state_d   = WAIT;
            end
            WAIT: begin
                if (cache_done || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                resp0_valid = ~winner_q;
                resp1_valid = winner_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- request latch, pointer and response data ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winner_q    <= 1'b0;
            last_q      <= 1'b1;
            cache_we    <= 1'b0;
            cache_addr  <= '0;
            cache_wdata <= '0;
            cache_size  <= '0;
            cache_clf   <= 1'b0;
            resp_data   <= '0;
        end else begin
            // Fields stay put from ISSUE until the next acceptance.
            if (accept) begin
                winner_q    <= sel;
                cache_we    <= sel ? we1    : we0;
                cache_addr  <= sel ? addr1  : addr0;
                cache_wdata <= sel ? wdata1 : wdata0;
                cache_size  <= sel ? size1  : size0;
                cache_clf   <= sel ? clf1   : clf0;
            end
            // Leaving WAIT: completion data wins over a simultaneous timeout,
            // and a timed-out response returns zero data.
            if ((state_q == WAIT) && (state_d == RESP)) begin
                last_q    <= winner_q;
                resp_data <= cache_done ? cache_rdata : '0;
            end
        end
    end

`ifdef CACHE_ARB_TIMEOUT_EN
    // The counter holds the number of WAIT cycles already spent without
    // completion, so it reaches TIMEOUT on the edge that ends the
    // TIMEOUT-th such cycle; that edge is where the FSM leaves for RESP.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] wait_cnt_q;
    logic       resp_err_q;

    assign timeout_hit = (state_q == WAIT) && !cache_done && (wait_cnt_q == TIMEOUT_LAST);
    assign resp_err    = resp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= 8'd0;
            resp_err_q <= 1'b0;
        end else begin
            if (state_q == ISSUE) begin
                wait_cnt_q <= 8'd0;
            end else if ((state_q == WAIT) && !cache_done) begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end
            if ((state_q == WAIT) && cache_done) begin
                resp_err_q <= 1'b0;
            end else if (timeout_hit) begin
                resp_err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign resp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_port_arbiter
//
// Directed bench for cache_port_arbiter. Requests are queued per port and
// driven by small requester processes; a cache model answers each issue
// after a chosen latency. Expected issue fields and expected responses are
// queued when a request is queued and compared when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_cache_port_arbiter;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req0, we0, clf0, req1, we1, clf1;
    logic [63:0] addr0, wdata0, addr1, wdata1;
    logic [2:0]  size0, size1;

    wire         ack0, ack1, resp0_valid, resp1_valid, resp_err;
    wire [127:0] resp_data;
    wire         cache_req, cache_we, cache_clf, busy;
    wire [63:0]  cache_addr, cache_wdata;
    wire [2:0]   cache_size;

    logic         model_done = 1'b0;
    logic         stray_done = 1'b0;
    logic [127:0] model_rdata = '0;
    wire          cache_done  = model_done | stray_done;
    wire  [127:0] cache_rdata = model_done ? model_rdata : 128'hBAD0_BAD0;

    cache_port_arbiter #(
        .ADDR_W (64),
        .WDATA_W(64),
        .RDATA_W(128),
        .TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .we0        (we0),
        .addr0      (addr0),
        .wdata0     (wdata0),
        .size0      (size0),
        .clf0       (clf0),
        .ack0       (ack0),
        .resp0_valid(resp0_valid),
        .req1       (req1),
        .we1        (we1),
        .addr1      (addr1),
        .wdata1     (wdata1),
        .size1      (size1),
        .clf1       (clf1),
        .ack1       (ack1),
        .resp1_valid(resp1_valid),
        .resp_err   (resp_err),
        .resp_data  (resp_data),
        .cache_req  (cache_req),
        .cache_we   (cache_we),
        .cache_addr (cache_addr),
        .cache_wdata(cache_wdata),
        .cache_size (cache_size),
        .cache_clf  (cache_clf),
        .cache_done (cache_done),
        .cache_rdata(cache_rdata),
        .busy       (busy)
    );

    typedef struct {
        int           port;
        logic         we;
        logic [63:0]  addr;
        logic [63:0]  wdata;
        logic [2:0]   size;
        logic         clf;
        logic [127:0] rdata;
    } txn_t;

    typedef struct {
        logic [127:0] data;
        logic         err;
        int           lat;
    } rsp_t;

    txn_t pq0[$];
    txn_t pq1[$];
    txn_t exp_issue[$];
    rsp_t exp_rsp0[$];
    rsp_t exp_rsp1[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int cache_lat = 1;
    bit cache_hang = 1'b0;
    int issue_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int port, input logic we, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [2:0] size, input logic clf,
                        input logic [127:0] rdata, input logic [127:0] exp_data,
                        input logic exp_err, input int lat);
        txn_t t;
        rsp_t r;
        t.port = port; t.we = we; t.addr = addr; t.wdata = wdata;
        t.size = size; t.clf = clf; t.rdata = rdata;
        r.data = exp_data; r.err = exp_err; r.lat = lat;
        exp_issue.push_back(t);
        if (port == 0) begin
            pq0.push_back(t);
            exp_rsp0.push_back(r);
        end else begin
            pq1.push_back(t);
            exp_rsp1.push_back(r);
        end
    endtask

    task automatic drive_port(input int n, input logic rq, input txn_t t);
        if (n == 0) begin
            req0 = rq; we0 = t.we; addr0 = t.addr; wdata0 = t.wdata; size0 = t.size; clf0 = t.clf;
        end else begin
            req1 = rq; we1 = t.we; addr1 = t.addr; wdata1 = t.wdata; size1 = t.size; clf1 = t.clf;
        end
    endtask

    // Requester: raise req with the head request, hold until ack is seen,
    // then at the next edge either present the next request or drop req.
    task automatic run_port(input int n);
        txn_t t;
        bit   have;
        bit   acked;
        forever begin
            @(posedge clk);
            #1;
            have = (n == 0) ? (pq0.size() > 0) : (pq1.size() > 0);
            if (!have) begin
                if (n == 0) req0 = 1'b0; else req1 = 1'b0;
            end else begin
                if (n == 0) t = pq0[0]; else t = pq1[0];
                drive_port(n, 1'b1, t);
                acked = 1'b0;
                for (int k = 0; k < 300 && !acked; k++) begin
                    @(negedge clk);
                    acked = (n == 0) ? ack0 : ack1;
                end
                if (!acked) begin
                    checks++;
                    failures++;
                    $error("FAIL ack_timeout port=%0d observed=0 expected=1", n);
                end
                if (n == 0) void'(pq0.pop_front()); else void'(pq1.pop_front());
            end
        end
    endtask

    initial run_port(0);
    initial run_port(1);

    // Cache model: checks the issued fields and answers after cache_lat cycles.
    initial begin : cache_model
        txn_t t;
        forever begin
            @(negedge clk);
            if (cache_req) begin
                issue_cyc = cyc;
                if (exp_issue.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL unexpected_issue observed=1 expected=0");
                end else begin
                    t = exp_issue.pop_front();
                    chk("issue_ack", {ack1, ack0}, (t.port == 0) ? 2'b01 : 2'b10);
                    chk("issue_we", cache_we, t.we);
                    chk("issue_addr", cache_addr, t.addr);
                    chk("issue_wdata", cache_wdata, t.wdata);
                    chk("issue_size", cache_size, t.size);
                    chk("issue_clf", cache_clf, t.clf);
                    if (!cache_hang) begin
                        for (int i = 0; i < cache_lat; i++) @(posedge clk);
                        #1;
                        model_done  = 1'b1;
                        model_rdata = t.rdata;
                        @(posedge clk);
                        #1;
                        model_done  = 1'b0;
                    end
                end
            end
        end
    end

    // Response monitor: pops the expected response of the responding port.
    initial begin : resp_monitor
        rsp_t r;
        bit   have;
        forever begin
            @(negedge clk);
            if (resp0_valid || resp1_valid) begin
                chk("resp_onehot", {resp1_valid, resp0_valid} == 2'b11, 1'b0);
                have = resp1_valid ? (exp_rsp1.size() > 0) : (exp_rsp0.size() > 0);
                if (!have) begin
                    checks++;
                    failures++;
                    $error("FAIL unexpected_resp port=%0d observed=1 expected=0", resp1_valid ? 1 : 0);
                end else begin
                    r = resp1_valid ? exp_rsp1.pop_front() : exp_rsp0.pop_front();
                    chk("resp_data", resp_data, r.data);
                    chk("resp_err", resp_err, r.err);
                    chk("resp_latency", cyc - issue_cyc, r.lat + 1);
                end
            end
        end
    end

    task automatic drain(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            done = (exp_issue.size() == 0) && (exp_rsp0.size() == 0) && (exp_rsp1.size() == 0) &&
                   (pq0.size() == 0) && (pq1.size() == 0) && !busy;
        end
        checks++;
        assert (done) else begin
            failures++;
            $error("FAIL drain_%s observed=pending expected=idle", tag);
        end
    endtask

    task automatic wait_issue(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            seen = cache_req;
        end
        checks++;
        assert (seen) else begin
            failures++;
            $error("FAIL issue_wait_%s observed=0 expected=1", tag);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_strobes"}, {ack0, ack1, resp0_valid, resp1_valid, cache_req, busy}, 6'b0);
        chk({tag, "_err"}, resp_err, 1'b0);
        chk({tag, "_resp_data"}, resp_data, 128'h0);
        chk({tag, "_cache_ctl"}, {cache_we, cache_clf, cache_size}, 5'b0);
        chk({tag, "_cache_addr"}, cache_addr, 64'h0);
        chk({tag, "_cache_wdata"}, cache_wdata, 64'h0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0; size0 = '0; clf0 = 0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; size1 = '0; clf1 = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Tie with both ports held: grants alternate 0,1,0,1.
        cache_lat = 1;
        @(negedge clk);
        send(0, 1'b0, 64'h100, 64'h0, 3'd0, 1'b0, 128'hA0, 128'hA0, 1'b0, 1);
        send(1, 1'b0, 64'h200, 64'h0, 3'd0, 1'b0, 128'hB1, 128'hB1, 1'b0, 1);
        send(0, 1'b0, 64'h300, 64'h0, 3'd0, 1'b0, 128'hA2, 128'hA2, 1'b0, 1);
        send(1, 1'b0, 64'h400, 64'h0, 3'd0, 1'b0, 128'hB3, 128'hB3, 1'b0, 1);
        drain("tie", 200);

        // Single read on port 0, minimum latency.
        @(negedge clk);
        send(0, 1'b0, 64'h8, 64'h0, 3'd0, 1'b0,
             128'h0123_4567_89AB_CDEF_0000_0000_0000_DEAD,
             128'h0123_4567_89AB_CDEF_0000_0000_0000_DEAD, 1'b0, 1);
        drain("single_read", 50);

        // Write pass-through on port 1 with a slower cache.
        cache_lat = 3;
        @(negedge clk);
        send(1, 1'b1, 64'h40, 64'h1234, 3'd3, 1'b0, 128'h77, 128'h77, 1'b0, 3);
        drain("write", 50);

        // Line flush on port 0.
        cache_lat = 2;
        @(negedge clk);
        send(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFC0, 64'h0, 3'd7, 1'b1,
             128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000,
             128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, 1'b0, 2);
        drain("clf", 50);

        // Stray completion while idle: no response, FSM stays idle.
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_idle_busy", busy, 1'b0);

        // Stray completion during ISSUE: ignored, real completion later.
        cache_lat = 2;
        send(0, 1'b0, 64'h80, 64'h0, 3'd0, 1'b0, 128'hC0FFEE, 128'hC0FFEE, 1'b0, 2);
        wait_issue("stray");
        stray_done = 1'b1;
        @(posedge clk);
        #1;
        stray_done = 1'b0;
        drain("stray_issue", 50);

        // Reset while in WAIT: everything clears at once, then normal service.
        cache_hang = 1'b1;
        @(negedge clk);
        send(0, 1'b0, 64'h28, 64'h0, 3'd0, 1'b0, 128'h0, 128'h0, 1'b0, 1);
        wait_issue("reset_wait");
        @(negedge clk);
        @(negedge clk);
        chk("mid_wait_busy", busy, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_rsp0.delete();
        repeat (2) @(negedge clk);
        chk("held_reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        cache_hang = 1'b0;
        cache_lat = 1;
        @(negedge clk);
        send(0, 1'b0, 64'h30, 64'h0, 3'd0, 1'b0, 128'h5A5A, 128'h5A5A, 1'b0, 1);
        drain("after_reset", 50);

`ifdef CACHE_ARB_TIMEOUT_EN
        // No completion: times out after TO WAIT cycles with err and zero data.
        cache_hang = 1'b1;
        @(negedge clk);
        send(0, 1'b0, 64'h50, 64'h0, 3'd0, 1'b0, 128'h0, 128'h0, 1'b1, TO);
        drain("timeout", 50);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_done_busy", busy, 1'b0);
        chk("late_done_data", resp_data, 128'h0);
        cache_hang = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
